// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the nibble-serial add/subtract sequencer.
// State encoding 2'd3 is unused and recovers to IDLE.
package serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester-side bundle: start/operands in, busy/done/results out.
// master = requester, slave = sequencer.
interface serial_adder_ctrl_if #(
    parameter int W = 16
);
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl_rca4.sv
// One 4-bit ripple-carry adder slice, purely combinational.
// Shared by every nibble of a serial operation.
module rca4
    import serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    // Ripple the carry bit by bit through the slice
    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer around a shared rca4.
// One nibble per clock LSB first; results published on DONE.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             c_q, c_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic                accept;
    logic [IDX_W+1:0]    lo;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_c;

    assign lo    = {idx_q, 2'b00};
    assign nib_a = a_q[lo +: NIBBLE_W];
    assign nib_b = b_q[lo +: NIBBLE_W];

    rca4 u_rca4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (c_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Next-state: accept, per-nibble step, publish on last nibble
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: accept = bus.start;
            RUN: begin
                work_d[lo +: NIBBLE_W] = nib_s;
                c_d = nib_c;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    sum_d   = work_d;
                    cout_d  = nib_c;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                              (work_d[W-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                accept = bus.start;
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            idx_d   = '0;
            a_d     = bus.a;
            b_d     = bus.sub ? ~bus.b : bus.b;
            c_d     = bus.sub | bus.cin;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Register FSM, datapath and outputs; rst wins over start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random bench for serial_adder_ctrl (NIBBLES=4).
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.W(16)) bus ();

    serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_err  = 0;
    int n_acc  = 0;
    int n_done = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Integer reference: {ovf, cout, sum}
    function automatic logic [17:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s,
                                          input logic c);
        int ua, ub, sa, sb, sr, ur;
        logic co;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            ur = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            ur = ua + ub + int'(c);
            co = (ur > 65535);
            sr = sa + sb + int'(c);
        end
        return {(sr > 32767) || (sr < -32768), co, ur[15:0]};
    endfunction

    task automatic op(input string tag,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic c,
                      input logic [15:0] es, input logic ec,
                      input logic eo, input bit noise);
        int busy_n;
        int lat;
        busy_n = 0;
        lat = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.sub = s;
        bus.cin = c;
        n_acc++;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_n++;
            bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.sub = 1'($urandom_range(0, 1));
            bus.cin = 1'($urandom_range(0, 1));
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, lat, 5);
        check({tag, "_busy"}, busy_n, 4);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 0);
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.done), 0);
        check({tag, "_hold"}, 32'(bus.sum), 32'(es));
    endtask

    // Count done pulses; busy and done must never coincide
    always @(negedge clk) begin
        if (bus.done) n_done++;
        if (!rst) check("busy_done_excl", 32'(bus.busy & bus.done), 0);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs, rc;
        logic [17:0] r;
        int          seen;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_sum", 32'(bus.sum), 0);
        check("rst_cout", 32'(bus.cout), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0;

        op("t1", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0);
        op("t2a", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 0);
        op("t2b", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        op("t3a", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0);
        op("t3b", 16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1, 0);

        // start held high, a changes every cycle; accepts at 0, 5, 10
        for (int j = 0; j <= 15; j++) begin
            if (j > 0) begin
                if (j % 5 == 0) begin
                    check("t4_done", 32'(bus.done), 1);
                    check("t4_sum", 32'(bus.sum),
                          32'(16'(16'h1101 + j - 5)));
                end else begin
                    check("t4_done", 32'(bus.done), 0);
                    check("t4_busy", 32'(bus.busy), 1);
                end
            end
            bus.start = (j < 15);
            bus.a = 16'(16'h1000 + j);
            bus.b = 16'h0101;
            bus.sub = 1'b0;
            bus.cin = 1'b0;
            if (j % 5 == 0 && j < 15) n_acc++;
            @(negedge clk);
        end
        check("t4_idle_done", 32'(bus.done), 0);

        // reset while RUN at idx=2
        bus.start = 1'b1;
        bus.a = 16'h2222;
        bus.b = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_done", 32'(bus.done), 0);
        check("t5_sum", 32'(bus.sum), 0);
        check("t5_cout", 32'(bus.cout), 0);
        check("t5_ovf", 32'(bus.ovf), 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("t5_no_done", seen, 0);
        op("t5_fresh", 16'h2222, 16'h1111, 0, 1, 16'h3334, 0, 0, 0);

        // random ops with stray start pulses while busy
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            r  = model(ra, rb, rs, rc);
            op("t6", ra, rb, rs, rc, r[15:0], r[16], r[17], 1);
        end

        @(negedge clk);
        check("done_count", n_done, n_acc);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
